regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/waddr/wdata) between two write-back requesters.
  - Requester P: the main pipeline write-back stage.
  - Requester A: a multi-cycle auxiliary unit, e.g. a divider or multiplier.
- Fixed priority to P, with a starvation guard that forces an A grant after a bounded wait.
- Output is registered and drives the register file write port directly.

Parameters:
- DATA_W, 32, data width of write-back value
- ADDR_W, 5, register address width (2^ADDR_W registers)
- STARVE_MAX, 4, consecutive stalled cycles of A before A is forced; 0 = A has strict priority

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- p_valid  in  1  pipeline write request
- p_addr  in  ADDR_W  pipeline destination register
- p_data  in  DATA_W  pipeline write data
- p_ready  out  1  pipeline request accepted this cycle (0 = pipeline must stall)
- a_valid  in  1  aux unit write request
- a_addr  in  ADDR_W  aux destination register
- a_data  in  DATA_W  aux write data
- a_ready  out  1  aux request accepted this cycle
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- grant_src  out  1  source of the current rf_* write: 0 = P, 1 = A

Behaviour:
- Internal starvation counter cnt, width sufficient for STARVE_MAX, saturating.
- force = a_valid & (cnt == STARVE_MAX).
- Ready signals (combinational):
  - p_ready = ~force.
  - a_ready = force | ~p_valid.
  - Neither ready depends on its own valid.
- Handshakes:
  - P handshake = p_valid & p_ready.
  - A handshake = a_valid & a_ready.
  - At most one handshake per cycle, by construction.
- Simultaneous p_valid & a_valid:
  - P wins unless force is asserted.
  - On force, A wins and p_ready = 0.
- Counter update (per clock):
  - A waiting (a_valid & ~a_ready): cnt <= min(cnt+1, STARVE_MAX).
  - A handshake, or a_valid low: cnt <= 0.
- STARVE_MAX = 0: force = a_valid, so A always wins when valid.
- Latency:
  - A handshake in cycle N produces rf_we/rf_waddr/rf_wdata in cycle N+1, all registered.
  - grant_src is registered alongside.
- Register 0:
  - A handshake with addr == 0 is accepted (ready honoured) but rf_we stays 0 next cycle.
  - rf_waddr/rf_wdata still show the request; grant_src is updated.
- No handshake:
  - rf_we <= 0, rf_waddr <= 0, rf_wdata <= 0.
  - grant_src holds its value.
- Requesters must hold valid/addr/data stable until their handshake.
- Reset (rst = 0, any time):
  - Outputs rf_we = 0, rf_waddr = 0, rf_wdata = 0, grant_src = 0, cnt = 0.
  - Requests in flight are dropped.
  - p_ready = 1 and a_ready = 1 during reset.
- Reset release: the first edge with rst = 1 behaves as a normal cycle with cnt = 0.

Optional Feature:
- Macro: WB_ARB_SCOREBOARD_EN.
- When defined, extra ports are added:
  - a_issue (in 1), a_issue_addr (in ADDR_W): multi-cycle op issued.
  - rd_addr1, rd_addr2 (in ADDR_W): source registers of the instruction in decode.
  - busy (out 2^ADDR_W): per-register busy bitmask.
  - hazard (out 1).
- Busy bitmask update:
  - Bit set on a_issue with a_issue_addr != 0.
  - Bit cleared on the A handshake for that address.
  - Set and clear of the same bit in one cycle: set wins.
- hazard = busy[rd_addr1] | busy[rd_addr2] | (p_valid & busy[p_addr]), combinational.
  - The p_addr term also forces p_ready = 0 (write-after-write protection).
- busy resets to 0.
- When not defined, none of these ports or this logic exist.

Test Plan:
- Only P: p_valid=1, p_addr=3, p_data=0x11 in cycle N → p_ready=1; cycle N+1 rf_we=1, rf_waddr=3, rf_wdata=0x11, grant_src=0.
- Only A: a_valid=1, a_addr=7, a_data=0xABCD → a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=7, grant_src=1.
- Contention with STARVE_MAX=4: p_valid and a_valid held high → P granted 4 cycles, a_ready=0, cnt reaches 4.
  - 5th cycle: p_ready=0, a_ready=1, A written.
  - cnt returns to 0; P is granted again afterwards.
- Address zero: a_valid=1, a_addr=0, a_data=0xFFFF → a_ready=1; next cycle rf_we=0, grant_src=1.
- Async reset mid-contention: rst=0 asserted between clock edges with cnt=3 → rf_we=0 and all outputs 0 immediately.
  - After release with only a_valid=1: A is granted in the first cycle.
- Scoreboard (WB_ARB_SCOREBOARD_EN): a_issue with addr 9 → busy[9]=1.
  - rd_addr1=9 → hazard=1.
  - A handshake to 9 → busy[9]=0 next cycle and hazard=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// =============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the register-file write port between the pipeline (P) and
//            a multi-cycle aux unit (A). P has fixed priority; a starvation
//            guard forces an A grant. Optional WAW scoreboard: WB_ARB_SCOREBOARD_EN
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_data,
    output logic              p_ready,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              grant_src
`ifdef WB_ARB_SCOREBOARD_EN
   ,input  logic                 a_issue,
    input  logic [ADDR_W-1:0]    a_issue_addr,
    input  logic [ADDR_W-1:0]    rd_addr1,
    input  logic [ADDR_W-1:0]    rd_addr2,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 hazard
`endif
);

    localparam int              CNT_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              grant_src_q, grant_src_d;

    logic force_a;
    logic p_block;
    logic p_hs;
    logic a_hs;

`ifdef WB_ARB_SCOREBOARD_EN
    logic [2**ADDR_W-1:0] busy_q, busy_d;
`endif

    always_comb begin
        force_a = a_valid & (cnt_q == CNT_MAX);
        p_block = 1'b0;
`ifdef WB_ARB_SCOREBOARD_EN
        // P may not overwrite a register still owed a result by the aux unit
        p_block = busy_q[p_addr];
`endif
        // Both readies are held high while in reset (rst is active-low)
        p_ready = ~rst | (~force_a & ~p_block);
        a_ready = ~rst | force_a | ~p_valid | p_block;
        p_hs    = p_valid & p_ready;
        a_hs    = a_valid & a_ready;

        if (a_valid & ~a_ready) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        rf_we_d     = 1'b0;
        rf_waddr_d  = '0;
        rf_wdata_d  = '0;
        grant_src_d = grant_src_q;
        if (a_hs) begin
            rf_we_d     = (a_addr != '0);
            rf_waddr_d  = a_addr;
            rf_wdata_d  = a_data;
            grant_src_d = 1'b1;
        end else if (p_hs) begin
            rf_we_d     = 1'b1;
            rf_waddr_d  = p_addr;
            rf_wdata_d  = p_data;
            grant_src_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            grant_src_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            grant_src_q <= grant_src_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign grant_src = grant_src_q;

`ifdef WB_ARB_SCOREBOARD_EN
    // Clear on write-back first so a same-cycle re-issue leaves the bit set
    always_comb begin
        busy_d = busy_q;
        if (a_hs) begin
            busy_d[a_addr] = 1'b0;
        end
        if (a_issue && (a_issue_addr != '0)) begin
            busy_d[a_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign hazard = busy_q[rd_addr1] | busy_q[rd_addr2] | (p_valid & busy_q[p_addr]);
`endif

endmodule

`default_nettype wire
